// File: rtl/div_seq_unit_pkg.sv
// Shared types and constants for the sequential divider slice.
package div_seq_unit_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Bit of the stall bus that holds the EX stage.
  localparam int unsigned STALL_EX = 3;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, select.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              bit_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  always_comb begin
    shifted = {rem, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[DATA_W];
    // On restore the shifted value is below the divisor, so it fits DATA_W bits.
    rem_next = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/div_seq_unit.sv
// Multi-cycle signed/unsigned restoring divider for EX; result is {remainder, quotient}.
module div_seq_unit
  import div_seq_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  annul,
  output logic [2*DATA_W-1:0]   result,
  output logic                  ready,
  output logic                  stallreq_for_ex
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dsr;
  logic [DATA_W-1:0] rem;
  logic              sign_q;
  logic              sign_r;

  logic [DATA_W-1:0] op1_abs;
  logic [DATA_W-1:0] op2_abs;
  logic [DATA_W-1:0] rem_next;
  logic [DATA_W-1:0] quo_next;
  logic              q_bit;

  logic unused_stall;
  assign unused_stall = ^{stall[STALL_W-1:STALL_EX+1], stall[STALL_EX-1:0]};

  always_comb begin
    op1_abs  = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
    op2_abs  = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
    quo_next = {dvd[DATA_W-2:0], q_bit};
  end

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem),
    .bit_in   (dvd[DATA_W-1]),
    .divisor  (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign stallreq_for_ex = start & ~annul & (state != DIV_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DIV_FREE;
      cnt    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready <= 1'b0;
          if (start && !annul) begin
            if (opdata2 == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state  <= DIV_ON;
              dvd    <= op1_abs;
              dsr    <= op2_abs;
              rem    <= '0;
              cnt    <= '0;
              sign_q <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
              sign_r <= signed_div & opdata1[DATA_W-1];
            end
          end
        end
        DIV_BY_ZERO: begin
          if (annul) begin
            state <= DIV_FREE;
          end else begin
            // Operands are still held by the pipeline here, so the raw dividend is valid.
            result <= {opdata1, {DATA_W{1'b1}}};
            ready  <= 1'b1;
            state  <= DIV_END;
          end
        end
        DIV_ON: begin
          if (annul) begin
            state <= DIV_FREE;
          end else begin
            rem <= rem_next;
            dvd <= quo_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              result <= {sign_r ? -rem_next : rem_next, sign_q ? -quo_next : quo_next};
              ready  <= 1'b1;
              state  <= DIV_END;
            end
          end
        end
        DIV_END: begin
          if (annul || !stall[STALL_EX]) begin
            ready <= 1'b0;
            state <= DIV_FREE;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Directed self-checking bench for div_seq_unit with hand-computed vectors.
module tb_div_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq_for_ex;

  int checks = 0;
  int errors = 0;

  div_seq_unit #(.DATA_W(32), .STALL_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .start           (start),
    .signed_div      (signed_div),
    .opdata1         (opdata1),
    .opdata2         (opdata2),
    .annul           (annul),
    .result          (result),
    .ready           (ready),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a division, measure latency and stall-request cycles, then hold the
  // result in END for 'hold' extra cycles using stall[3].
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp,
                         input int exp_lat, input int hold);
    int cyc = 0;
    int req = 0;
    start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
    #1;
    while (!ready && cyc < 60) begin
      if (stallreq_for_ex) req++;
      tick();
      cyc++;
    end
    check({tag, ":latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, ":stallreq_cycles"}, 64'(req), 64'(exp_lat));
    check({tag, ":end_stallreq"}, 64'(stallreq_for_ex), 64'd0);
    start = 1'b0;
    for (int k = 0; k <= hold; k++) begin
      stall = (k < hold) ? 6'b001000 : 6'b000000;
      #1;
      check({tag, ":ready"}, 64'(ready), 64'd1);
      check({tag, ":result"}, result, exp);
      tick();
    end
    stall = '0;
    check({tag, ":ready_drop"}, 64'(ready), 64'd0);
  endtask

  initial begin
    int seen;
    rst = 1'b1; stall = '0; start = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0; annul = 1'b0;
    tick(); tick();
    check("reset:ready", 64'(ready), 64'd0);
    check("reset:result", result, 64'd0);
    check("reset:stallreq", 64'(stallreq_for_ex), 64'd0);
    rst = 1'b0;
    tick();

    run_div("u100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 33, 0);
    run_div("s-100_7", 1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE, 32'hFFFFFFF2},    33, 0);
    run_div("s_min_m1",1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},           33, 0);
    run_div("u_min_m1",1'b0, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0},           33, 0);
    run_div("u_max_16",1'b0, 32'hFFFFFFFF,   32'h10,         {32'hF, 32'h0FFFFFFF},           33, 0);
    run_div("s7_-2",   1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1, 32'hFFFFFFFD},           33, 0);
    run_div("div0",    1'b0, 32'h1234,       32'h0,          {32'h1234, 32'hFFFFFFFF},        2,  0);
    run_div("stall3",  1'b0, 32'd1000,       32'd3,          {32'd1, 32'd333},                33, 3);

    // Annul in the 10th ON cycle: no result, previous result kept, then FREE.
    start = 1'b1; signed_div = 1'b0; opdata1 = 32'd5000; opdata2 = 32'd9;
    for (int i = 0; i < 10; i++) tick();
    check("annul:req_before", 64'(stallreq_for_ex), 64'd1);
    annul = 1'b1;
    #1;
    check("annul:req_during", 64'(stallreq_for_ex), 64'd0);
    tick();
    annul = 1'b0; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) seen++;
      tick();
    end
    check("annul:no_ready", 64'(seen), 64'd0);
    check("annul:result_kept", result, {32'd1, 32'd333});
    run_div("post_annul", 1'b0, 32'd5000, 32'd9, {32'd5, 32'd555}, 33, 0);

    // Reset in the 15th ON cycle aborts with cleared outputs.
    start = 1'b1; signed_div = 1'b1; opdata1 = 32'hFFFF; opdata2 = 32'h10;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1;
    tick();
    check("rst_mid:ready", 64'(ready), 64'd0);
    check("rst_mid:result", result, 64'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    run_div("post_rst", 1'b1, 32'hFFFF, 32'h10, {32'hF, 32'hFFF}, 33, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
